// File: rtl/fifo_unpack_ctrl.sv
// fifo_unpack_ctrl: accepts 32-bit words from the processor side, writes
// them into a 32-to-8 unpack FIFO and presents the bytes one at a time,
// little-endian, to a DMA channel until the programmed byte count is spent.
module fifo_unpack_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] byte_count,
  input  logic [31:0]      word_in,
  input  logic             word_valid,
  output logic             word_ready,
  output logic [7:0]       byte_out,
  output logic             byte_valid,
  input  logic             byte_ready,
  output logic             fifo_write,
  output logic [31:0]      fifo_wdata,
  output logic [1:0]       fifo_read,
  input  logic [7:0]       fifo_rdata,
  output logic             busy,
  output logic             tc
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_WORD,
    S_FETCH,
    S_PRESENT,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [CNT_W-1:0] r_remaining;
  logic [CNT_W-1:0] w_remaining_next;
  logic [1:0]       r_lane;
  logic [1:0]       w_lane_next;

  // State, remaining-byte counter and lane register with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_remaining <= '0;
      r_lane      <= 2'd0;
    end else begin
      r_state     <= w_state_next;
      r_remaining <= w_remaining_next;
      r_lane      <= w_lane_next;
    end
  end

  // Next-state logic: abort wins over every other transition out of a busy state.
  always_comb begin
    w_state_next     = r_state;
    w_remaining_next = r_remaining;
    w_lane_next      = r_lane;
    if (r_state != S_IDLE && abort) begin
      w_state_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (byte_count != '0) begin
              w_remaining_next = byte_count;
              w_lane_next      = 2'd0;
              w_state_next     = S_WAIT_WORD;
            end else begin
              w_state_next = S_DONE;
            end
          end
        end
        S_WAIT_WORD: begin
          if (word_valid) begin
            w_lane_next  = 2'd0;
            w_state_next = S_FETCH;
          end
        end
        S_FETCH: begin
          w_state_next = S_PRESENT;
        end
        S_PRESENT: begin
          if (byte_ready) begin
            // Saturating decrement: the counter never wraps below zero.
            if (r_remaining != '0) begin
              w_remaining_next = r_remaining - CNT_W'(1);
            end
            if (r_remaining == CNT_W'(1)) begin
              w_state_next = S_DONE;
            end else if (r_lane == 2'd3) begin
              w_state_next = S_WAIT_WORD;
            end else begin
              w_lane_next  = r_lane + 2'd1;
              w_state_next = S_FETCH;
            end
          end
        end
        S_DONE: begin
          w_state_next = S_IDLE;
        end
        default: begin
          w_state_next = S_IDLE;
        end
      endcase
    end
  end

  // Outputs decode from state; gated by rst_n so they read zero while reset is held.
  always_comb begin
    word_ready = 1'b0;
    fifo_write = 1'b0;
    byte_valid = 1'b0;
    byte_out   = 8'h00;
    busy       = 1'b0;
    tc         = 1'b0;
    fifo_wdata = word_in;
    fifo_read  = r_lane;
    if (rst_n) begin
      busy = (r_state != S_IDLE);
      case (r_state)
        S_WAIT_WORD: begin
          word_ready = 1'b1;
          // The FIFO write still fires under abort; the word is simply dropped.
          fifo_write = word_valid;
        end
        S_PRESENT: begin
          byte_valid = 1'b1;
          byte_out   = fifo_rdata;
        end
        S_DONE: begin
          tc = 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_unpack_ctrl.sv
// Testbench for fifo_unpack_ctrl: table of full-rate transfers, hand-written
// corner-case sequences, and randomized transfers scored against a byte-stream model.
module tb_fifo_unpack_ctrl;

  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic             abort;
  logic [CNT_W-1:0] byte_count;
  logic [31:0]      word_in;
  logic             word_valid;
  logic             word_ready;
  logic [7:0]       byte_out;
  logic             byte_valid;
  logic             byte_ready;
  logic             fifo_write;
  logic [31:0]      fifo_wdata;
  logic [1:0]       fifo_read;
  logic [7:0]       fifo_rdata;
  logic             busy;
  logic             tc;

  fifo_unpack_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .byte_count(byte_count), .word_in(word_in), .word_valid(word_valid),
    .word_ready(word_ready), .byte_out(byte_out), .byte_valid(byte_valid),
    .byte_ready(byte_ready), .fifo_write(fifo_write), .fifo_wdata(fifo_wdata),
    .fifo_read(fifo_read), .fifo_rdata(fifo_rdata), .busy(busy), .tc(tc)
  );

  always #5 clk = ~clk;

  // External unpack FIFO: holds one word, registered byte-lane read.
  logic [31:0] fifo_mem = 32'h0;
  always @(posedge clk) begin
    if (fifo_write) fifo_mem <= fifo_wdata;
    fifo_rdata <= fifo_mem[{fifo_read, 3'b000} +: 8];
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor at the falling edge, where handshakes are stable for the next rising edge.
  logic [7:0] got_q[$];
  int words_acc = 0;
  int tc_cnt    = 0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (byte_valid && byte_ready) got_q.push_back(byte_out);
      if (fifo_write) words_acc++;
      if (tc) tc_cnt++;
      if (!byte_valid) chk("byte_out_idle", {24'h0, byte_out}, 32'h0);
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clr_mon;
    got_q.delete();
    words_acc = 0;
    tc_cnt    = 0;
  endtask

  task automatic start_xfer(input int cnt);
    start      = 1'b1;
    byte_count = CNT_W'(cnt);
    tick();
    start      = 1'b0;
  endtask

  logic [31:0] cur_w[4];

  // Drive an already-started transfer until the controller goes idle.
  task automatic drive_xfer(input int vp, input int rp, input int sp, input int budget);
    int cyc;
    cyc = 0;
    do begin
      word_valid = ($urandom_range(99) < vp);
      word_in    = cur_w[(words_acc > 3) ? 3 : words_acc];
      byte_ready = ($urandom_range(99) < rp);
      start      = ($urandom_range(99) < sp);
      byte_count = CNT_W'($urandom_range(20));
      tick();
      cyc++;
    end while (busy && cyc < budget);
    start      = 1'b0;
    word_valid = 1'b0;
    byte_ready = 1'b0;
    chk("xfer_timeout", {31'h0, busy}, 32'h0);
  endtask

  // Reference: the byte stream is the little-endian bytes of successive words, cut at count.
  task automatic check_stream(input string nm, input int cnt);
    int nb;
    logic [7:0] e;
    nb = got_q.size();
    chk({nm, "_nbytes"}, nb, cnt);
    for (int i = 0; i < cnt && i < nb; i++) begin
      e = 8'((cur_w[i / 4] >> (8 * (i % 4))) & 32'hFF);
      chk({nm, "_byte"}, {24'h0, got_q[i]}, {24'h0, e});
    end
    chk({nm, "_words"}, words_acc, (cnt + 3) / 4);
    chk({nm, "_tc"}, tc_cnt, 1);
    $display("xfer %s count=%0d bytes=%0d words=%0d tc=%0d", nm, cnt, nb, words_acc, tc_cnt);
  endtask

  task automatic wait_bv(input int budget);
    int k;
    k = 0;
    while (!byte_valid && k < budget) begin
      tick();
      k++;
    end
    chk("wait_byte_valid", {31'h0, byte_valid}, 32'h1);
  endtask

  typedef struct {
    int          cnt;
    logic [31:0] w0;
    logic [31:0] w1;
    logic [63:0] exp_b;
    int          exp_w;
  } vec_t;

  vec_t tbl[6];

  initial begin
    logic [7:0] lat_exp[4];
    int nb;

    tbl[0] = '{4, 32'hDDCCBBAA, 32'h0,        64'h00000000_DDCCBBAA, 1};
    tbl[1] = '{6, 32'h44332211, 32'h88776655, 64'h00006655_44332211, 2};
    tbl[2] = '{1, 32'h12345678, 32'h0,        64'h00000000_00000078, 1};
    tbl[3] = '{3, 32'hCAFEF00D, 32'h0,        64'h00000000_00FEF00D, 1};
    tbl[4] = '{8, 32'h03020100, 32'h07060504, 64'h07060504_03020100, 2};
    tbl[5] = '{5, 32'hA3A2A1A0, 32'hB3B2B1B0, 64'h000000B0_A3A2A1A0, 2};

    rst_n = 1'b0; start = 1'b0; abort = 1'b0; byte_count = '0;
    word_in = 32'h0; word_valid = 1'b0; byte_ready = 1'b0;
    repeat (3) tick();
    chk("rst_word_ready", {31'h0, word_ready}, 32'h0);
    chk("rst_byte_valid", {31'h0, byte_valid}, 32'h0);
    chk("rst_byte_out", {24'h0, byte_out}, 32'h0);
    chk("rst_fifo_write", {31'h0, fifo_write}, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_tc", {31'h0, tc}, 32'h0);
    chk("rst_fifo_read", {30'h0, fifo_read}, 32'h0);
    rst_n = 1'b1;
    tick();

    // Table-driven full-rate transfers.
    for (int t = 0; t < 6; t++) begin
      clr_mon();
      cur_w[0] = tbl[t].w0; cur_w[1] = tbl[t].w1; cur_w[2] = 32'h0; cur_w[3] = 32'h0;
      start_xfer(tbl[t].cnt);
      drive_xfer(100, 100, 0, 100);
      nb = got_q.size();
      chk("tbl_nbytes", nb, tbl[t].cnt);
      for (int i = 0; i < tbl[t].cnt && i < nb; i++)
        chk("tbl_byte", {24'h0, got_q[i]}, {24'h0, tbl[t].exp_b[i*8 +: 8]});
      chk("tbl_words", words_acc, tbl[t].exp_w);
      chk("tbl_tc", tc_cnt, 1);
      chk("tbl_busy_after", {31'h0, busy}, 32'h0);
      $display("xfer table[%0d] count=%0d bytes=%0d words=%0d", t, tbl[t].cnt, nb, words_acc);
    end

    // Cycle-exact latency for a single word.
    clr_mon();
    lat_exp[0] = 8'hAA; lat_exp[1] = 8'hBB; lat_exp[2] = 8'hCC; lat_exp[3] = 8'hDD;
    start_xfer(4);
    chk("lat_word_ready", {31'h0, word_ready}, 32'h1);
    chk("lat_busy", {31'h0, busy}, 32'h1);
    word_valid = 1'b1; word_in = 32'hDDCCBBAA; byte_ready = 1'b1;
    #1;
    chk("lat_fifo_write", {31'h0, fifo_write}, 32'h1);
    chk("lat_fifo_wdata", fifo_wdata, 32'hDDCCBBAA);
    tick();
    word_valid = 1'b0;
    chk("lat_fetch_ready", {31'h0, word_ready}, 32'h0);
    chk("lat_fetch_bv", {31'h0, byte_valid}, 32'h0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("lat_present_bv", {31'h0, byte_valid}, 32'h1);
      chk("lat_present_byte", {24'h0, byte_out}, {24'h0, lat_exp[i]});
      chk("lat_fifo_read", {30'h0, fifo_read}, 32'(i));
      tick();
      if (i < 3) chk("lat_gap_bv", {31'h0, byte_valid}, 32'h0);
      else       chk("lat_tc", {31'h0, tc}, 32'h1);
    end
    tick();
    chk("lat_tc_end", {31'h0, tc}, 32'h0);
    chk("lat_busy_end", {31'h0, busy}, 32'h0);
    byte_ready = 1'b0;
    $display("xfer latency count=4 bytes=%0d tc=%0d", got_q.size(), tc_cnt);

    // Back-pressure on the second byte.
    clr_mon();
    cur_w[0] = 32'hDDCCBBAA;
    start_xfer(4);
    word_valid = 1'b1; word_in = 32'hDDCCBBAA; byte_ready = 1'b0;
    tick();
    word_valid = 1'b0;
    wait_bv(10);
    byte_ready = 1'b1;
    tick();
    byte_ready = 1'b0;
    wait_bv(10);
    for (int i = 0; i < 5; i++) begin
      chk("stall_bv", {31'h0, byte_valid}, 32'h1);
      chk("stall_byte", {24'h0, byte_out}, 32'hBB);
      tick();
    end
    drive_xfer(100, 100, 0, 100);
    check_stream("stall", 4);

    // Zero-length transfer.
    clr_mon();
    start_xfer(0);
    chk("zero_word_ready", {31'h0, word_ready}, 32'h0);
    chk("zero_tc", {31'h0, tc}, 32'h1);
    chk("zero_busy", {31'h0, busy}, 32'h1);
    tick();
    chk("zero_tc_end", {31'h0, tc}, 32'h0);
    chk("zero_busy_end", {31'h0, busy}, 32'h0);
    chk("zero_words", words_acc, 0);
    $display("xfer zero count=0 tc=%0d words=%0d", tc_cnt, words_acc);

    // Abort while the second byte is presented.
    clr_mon();
    start_xfer(4);
    word_valid = 1'b1; word_in = 32'hDDCCBBAA; byte_ready = 1'b0;
    tick();
    word_valid = 1'b0;
    wait_bv(10);
    byte_ready = 1'b1;
    tick();
    byte_ready = 1'b0;
    wait_bv(10);
    chk("abort_byte", {24'h0, byte_out}, 32'hBB);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_busy", {31'h0, busy}, 32'h0);
    chk("abort_bv", {31'h0, byte_valid}, 32'h0);
    repeat (3) tick();
    chk("abort_no_tc", tc_cnt, 0);
    $display("xfer abort bytes=%0d tc=%0d", got_q.size(), tc_cnt);
    clr_mon();
    cur_w[0] = 32'h0000BEEF;
    start_xfer(2);
    drive_xfer(100, 100, 0, 100);
    check_stream("after_abort", 2);

    // Abort coincident with a word in WAIT_WORD: write strobe still fires.
    clr_mon();
    start_xfer(4);
    word_valid = 1'b1; word_in = 32'h01020304; abort = 1'b1;
    #1;
    chk("abortw_fifo_write", {31'h0, fifo_write}, 32'h1);
    tick();
    abort = 1'b0; word_valid = 1'b0;
    chk("abortw_busy", {31'h0, busy}, 32'h0);
    tick();
    chk("abortw_no_tc", tc_cnt, 0);
    $display("xfer abort_wait tc=%0d", tc_cnt);

    // Reset during WAIT_WORD, then start right after release.
    clr_mon();
    start_xfer(8);
    chk("rstm_word_ready", {31'h0, word_ready}, 32'h1);
    rst_n = 1'b0;
    #1;
    chk("rstm_during_ready", {31'h0, word_ready}, 32'h0);
    tick();
    chk("rstm_word_ready0", {31'h0, word_ready}, 32'h0);
    chk("rstm_busy", {31'h0, busy}, 32'h0);
    chk("rstm_bv", {31'h0, byte_valid}, 32'h0);
    chk("rstm_byte_out", {24'h0, byte_out}, 32'h0);
    chk("rstm_fifo_write", {31'h0, fifo_write}, 32'h0);
    chk("rstm_tc", {31'h0, tc}, 32'h0);
    chk("rstm_fifo_read", {30'h0, fifo_read}, 32'h0);
    rst_n = 1'b1;
    clr_mon();
    cur_w[0] = 32'h000000EE;
    start_xfer(1);
    chk("rstm_restart_busy", {31'h0, busy}, 32'h1);
    drive_xfer(100, 100, 0, 100);
    check_stream("after_reset", 1);

    // Start while busy is ignored.
    clr_mon();
    cur_w[0] = 32'h00005A6B;
    start_xfer(2);
    start = 1'b1; byte_count = '0;
    tick();
    start = 1'b0;
    chk("ignore_busy", {31'h0, busy}, 32'h1);
    chk("ignore_no_tc", tc_cnt, 0);
    drive_xfer(100, 100, 0, 100);
    check_stream("start_ignored", 2);

    // Randomized transfers with random handshakes and stray start pulses.
    for (int r = 0; r < 25; r++) begin
      int cnt;
      clr_mon();
      cnt = $urandom_range(16, 1);
      for (int k = 0; k < 4; k++) cur_w[k] = $urandom;
      start_xfer(cnt);
      drive_xfer(70, 60, 10, 500);
      check_stream("random", cnt);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
